// File: rtl/dat_mem_pkg.sv
// Shared types and helpers for the multi-port data memory.
// Holds the clear-FSM state type and the address-width helper.
package dat_mem_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dat_mem_clr_seq.sv
// Clear sequencer: FSM, sweep pointer, busy/done handshake, wr_drop.
// Ports: clk, rst_n, write_en, clr_req -> clr_busy, clr_done,
//        wr_drop, clr_we, clr_addr (array write strobe/address).
module dat_mem_clr_seq
  import dat_mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter bit CLR_ON_RST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write_en,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic                       wr_drop,
  output logic                       clr_we,
  output logic [addr_w(DEPTH)-1:0]   clr_addr
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_done;
  logic          r_drop;
  logic          r_boot;
  logic          w_req;

  // r_boot marks the first edge after reset release
  assign w_req = clr_req | (CLR_ON_RST & r_boot);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
      r_boot  <= 1'b1;
    end else begin
      r_boot <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_drop  <= 1'b0;
          end
        end
        CLEAR: begin
          if (write_en) r_drop <= 1'b1;
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == LAST) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_busy = (r_state == CLEAR);
  // a reset edge mid-sweep must not clear the word at ptr
  assign clr_we   = clr_busy & rst_n;
  assign clr_addr = r_ptr;
  assign clr_done = r_done;
  assign wr_drop  = r_drop;

endmodule

// File: rtl/dat_mem_mp.sv
// Multi-read-port data memory with built-in clear sequencer.
// Ports: clk, rst_n, write_en/waddr/data_in, raddr[]/data_out[],
//   clr_req -> clr_busy, clr_done, wr_drop.
// Option: DAT_MEM_MP_BYPASS_EN enables write-through forwarding.
module dat_mem_mp
  import dat_mem_pkg::*;
#(
  parameter int           W          = 8,
  parameter int           byte_count = 256,
  parameter int           RD_PORTS   = 2,
  parameter logic [W-1:0] CLR_VAL    = '0,
  parameter bit           CLR_ON_RST = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            write_en,
  input  logic [addr_w(byte_count)-1:0]   waddr,
  input  logic [W-1:0]                    data_in,
  input  logic [addr_w(byte_count)-1:0]   raddr [RD_PORTS],
  output logic [W-1:0]                    data_out [RD_PORTS],
  input  logic                            clr_req,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            wr_drop
);

  localparam int AW = addr_w(byte_count);

  logic [W-1:0]  r_mem [byte_count];
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_ext_we;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_data;

  dat_mem_clr_seq #(
    .DEPTH      (byte_count),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // external stores only land while idle
  assign w_ext_we = write_en & ~clr_busy;
  assign w_we     = w_clr_we | w_ext_we;
  assign w_addr   = w_clr_we ? w_clr_addr : waddr;
  assign w_data   = w_clr_we ? CLR_VAL : data_in;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_data;
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      data_out[i] = r_mem[raddr[i]];
`ifdef DAT_MEM_MP_BYPASS_EN
      if (w_ext_we && (raddr[i] == waddr))
        data_out[i] = data_in;
`endif
    end
  end

endmodule

// File: tb/tb_dat_mem_mp.sv
// Scoreboard bench for dat_mem_mp with a behavioural memory model.
// Second instance covers CLR_ON_RST with a 16-word memory.
module tb_dat_mem_mp;

  localparam int W  = 8;
  localparam int N  = 256;
  localparam int P  = 2;
  localparam int N2 = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_en;
  logic         clr_req;
  logic [7:0]   waddr;
  logic [W-1:0] data_in;
  logic [7:0]   raddr [P];
  logic [W-1:0] data_out [P];
  logic         clr_busy, clr_done, wr_drop;

  logic [3:0]   raddr2 [1];
  logic [W-1:0] dout2 [1];
  logic         busy2, done2, drop2;

  always #5 clk = ~clk;

  dat_mem_mp #(
    .W(W), .byte_count(N), .RD_PORTS(P), .CLR_ON_RST(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .waddr(waddr),
    .data_in(data_in), .raddr(raddr), .data_out(data_out),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_drop(wr_drop)
  );

  dat_mem_mp #(
    .W(W), .byte_count(N2), .RD_PORTS(1), .CLR_ON_RST(1'b1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .write_en(1'b0), .waddr(4'd0),
    .data_in(8'd0), .raddr(raddr2), .data_out(dout2),
    .clr_req(1'b0), .clr_busy(busy2), .clr_done(done2),
    .wr_drop(drop2)
  );

  typedef struct {
    int         kind;
    logic [7:0] exp;
    int         addr;
  } item_t;

  item_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [N];
  bit         known [N];
  int         clr_left = 0;
  bit         done_m = 0;
  bit         drop_m = 0;
  int         rel2 = 0;
  bit         cleared2 = 0;

  function automatic string kname(input int k);
    case (k)
      0:  return "rd_port0";
      1:  return "rd_port1";
      10: return "clr_busy";
      11: return "clr_done";
      12: return "wr_drop";
      20: return "rst_clr_busy";
      21: return "rst_clr_done";
      22: return "rst_clr_data";
      default: return "rst_wr_drop";
    endcase
  endfunction

  item_t      m_it;
  logic [7:0] m_act;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_it = q.pop_front();
      case (m_it.kind)
        0:  m_act = data_out[0];
        1:  m_act = data_out[1];
        10: m_act = {7'd0, clr_busy};
        11: m_act = {7'd0, clr_done};
        12: m_act = {7'd0, wr_drop};
        20: m_act = {7'd0, busy2};
        21: m_act = {7'd0, done2};
        22: m_act = dout2[0];
        default: m_act = {7'd0, drop2};
      endcase
      n_tests++;
      if (m_act !== m_it.exp) begin
        n_fail++;
        $display("FAIL %s addr=%0d got=%h expected=%h t=%0t",
                 kname(m_it.kind), m_it.addr, m_act, m_it.exp, $time);
      end
    end
  end

  task automatic chk(input string what, input logic got,
                     input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b t=%0t",
               what, got, exp, $time);
    end
  endtask

  task automatic wait_ok();
    chk("wait_expired", clr_left != 0, 1'b0);
    chk("wait_clr_busy", clr_busy, 1'b0);
  endtask

  task automatic push_checks();
    for (int p = 0; p < P; p++) begin
      int a = int'(raddr[p]);
      bit hit = 1'b0;
`ifdef DAT_MEM_MP_BYPASS_EN
      hit = write_en && (clr_left == 0) && (raddr[p] == waddr);
`endif
      if (hit) q.push_back('{p, data_in, a});
      else if (known[a]) q.push_back('{p, mem[a], a});
    end
    q.push_back('{10, {7'd0, clr_left > 0}, -1});
    q.push_back('{11, {7'd0, done_m}, -1});
    q.push_back('{12, {7'd0, drop_m}, -1});
    q.push_back('{20, {7'd0, (rel2 >= 1) && (rel2 <= N2)}, -1});
    q.push_back('{21, {7'd0, rel2 == N2 + 1}, -1});
    q.push_back('{23, 8'd0, -1});
    if (cleared2) q.push_back('{22, 8'd0, int'(raddr2[0])});
  endtask

  task automatic model_edge(input bit we, input int wa,
                            input logic [7:0] wd, input bit req,
                            input bit rst);
    if (!rst) begin
      if (we && clr_left == 0) begin
        mem[wa] = wd; known[wa] = 1'b1;
      end
      clr_left = 0; done_m = 0; drop_m = 0;
      rel2 = 0;
    end else begin
      done_m = 0;
      if (clr_left == 0) begin
        if (we) begin
          mem[wa] = wd; known[wa] = 1'b1;
        end
        if (req) begin
          clr_left = N; drop_m = 0;
        end
      end else begin
        if (we) drop_m = 1;
        mem[N - clr_left] = 8'h00;
        known[N - clr_left] = 1'b1;
        clr_left--;
        if (clr_left == 0) done_m = 1;
      end
      if (rel2 < 100000) rel2++;
      if (rel2 == N2 + 1) cleared2 = 1;
    end
  endtask

  task automatic cycle(input bit we, input int wa, input logic [7:0] wd,
                       input bit req, input bit rst, input int ra0,
                       input int ra1, input bit chk_en);
    write_en  = we;
    waddr     = wa[7:0];
    data_in   = wd;
    clr_req   = req;
    rst_n     = rst;
    raddr[0]  = ra0[7:0];
    raddr[1]  = ra1[7:0];
    raddr2[0] = ra0[3:0];
    if (chk_en) push_checks();
    @(posedge clk);
    model_edge(we, wa, wd, req, rst);
    #1;
  endtask

  function automatic int rnd(input int n);
    return int'($urandom_range(n - 1, 0));
  endfunction

  task automatic idle_rd();
    cycle(0, 0, 8'h00, 0, 1, rnd(N), rnd(N), 1);
  endtask

  task automatic fill_ff();
    for (int a = 0; a < N; a++)
      cycle(1, a, 8'hFF, 0, 1, rnd(N), rnd(N), 1);
  endtask

  task automatic readback();
    for (int a = 0; a < N; a += 2)
      cycle(0, 0, 8'h00, 0, 1, a, a + 1, 1);
  endtask

  initial begin
    for (int a = 0; a < N; a++) known[a] = 1'b0;
    cycle(0, 0, 8'h00, 0, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 0, 1);
    chk("reset_clr_busy", clr_busy, 1'b0);
    chk("reset_clr_done", clr_done, 1'b0);
    chk("reset_wr_drop", wr_drop, 1'b0);

    cycle(1, 4, 8'hA5, 0, 1, 0, 0, 1);
    cycle(1, 55, 8'h3C, 0, 1, 0, 0, 1);
    cycle(0, 0, 8'h00, 0, 1, 4, 55, 1);

    cycle(1, 10, 8'h11, 0, 1, 0, 0, 1);
    cycle(1, 10, 8'h77, 0, 1, 10, 10, 1);
    cycle(0, 0, 8'h00, 0, 1, 10, 4, 1);

    fill_ff();
    cycle(0, 0, 8'h00, 1, 1, 128, 0, 1);
    for (int k = 0; k < N + 20 && clr_left > 0; k++) begin
      if (k == 60) cycle(1, 128, 8'h5A, 0, 1, 128, 200, 1);
      else if (k == 70) cycle(0, 0, 8'h00, 1, 1, rnd(N), rnd(N), 1);
      else idle_rd();
    end
    wait_ok();
    idle_rd();
    idle_rd();
    readback();
    cycle(0, 0, 8'h00, 1, 1, 0, 0, 1);
    for (int k = 0; k < N + 20 && clr_left > 0; k++) idle_rd();
    wait_ok();
    idle_rd();

    fill_ff();
    cycle(0, 0, 8'h00, 1, 1, 0, 0, 1);
    for (int k = 0; k < N && clr_left > N - 100; k++) idle_rd();
    cycle(0, 0, 8'h00, 0, 0, 99, 100, 1);
    idle_rd();
    idle_rd();
    readback();

    for (int k = 0; k < 600; k++)
      cycle($urandom_range(2, 0) == 0, rnd(N), 8'($urandom),
            $urandom_range(59, 0) == 0, 1, rnd(N), rnd(N), 1);
    for (int k = 0; k < N + 20 && clr_left > 0; k++) idle_rd();
    wait_ok();
    idle_rd();
    readback();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dat_mem_mp.md
# dat_mem_mp

Multi-read-port, parametrised data memory with a built-in clear sequencer. It is the next generation of the design's byte-wide data memory. It keeps one clocked write port and combinational reads, generalises word width, depth and read-port count, and adds a hardware clear engine with a busy/done handshake. The clear engine lets the encryption datapath zero the message and result areas between runs without spending instruction cycles.

## Interface
- W, 8, word width in bits
- byte_count, 256, depth in words (power of two, ≥ 4)
- RD_PORTS, 2, number of independent combinational read ports (1–4)
- CLR_VAL, '0, W-bit value written by the clear sequencer
- CLR_ON_RST, 0, when 1, a clear sequence starts automatically on reset release

- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- write_en  in  1  external write (store) enable
- waddr  in  $clog2(byte_count)  external write pointer
- data_in  in  W  external write data
- raddr  in  RD_PORTS × $clog2(byte_count)  read pointers (unpacked array)
- data_out  out  RD_PORTS × W  read data (unpacked array)
- clr_req  in  1  request a full-memory clear
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when the last word has been cleared
- wr_drop  out  1  sticky flag: an external write was discarded during a clear

Clock and reset: one clock, `clk`. Reset is `rst_n`, synchronous and active-low.

## Operation
- Reads: data_out[i] = core[raddr[i]], combinational and independent per port. Contents are never reset.
- Writes: on posedge, if write_en and state IDLE, core[waddr] <= data_in.
- Clear FSM states:
  - IDLE → CLEAR when clr_req=1 at posedge. On entry, ptr <= 0 and wr_drop <= 0.
  - CLEAR: each posedge, core[ptr] <= CLR_VAL and ptr <= ptr+1.
  - CLEAR → IDLE at the posedge that writes ptr = byte_count-1. clr_done pulses high for the following cycle.
- clr_req while in CLEAR is ignored. There is no queueing and no restart.
- write_en while in CLEAR: the write is discarded and wr_drop <= 1. wr_drop holds until reset or until the next accepted clr_req.
- Same-edge write_en and clr_req in IDLE: the write is performed and the clear starts. The clear later overwrites that word.
- Reads during CLEAR return the current array contents, a mix of cleared and old words. No stall is applied.
- ptr is $clog2(byte_count) bits wide and wraps naturally. The terminal count is detected on ptr == byte_count-1, not on overflow.

## Timing
- Reset values while rst_n=0: state IDLE, ptr 0, clr_busy 0, clr_done 0, wr_drop 0. data_out stays combinational from the array.
- With CLR_ON_RST=1, the first posedge with rst_n=1 behaves as an accepted clr_req.
- Reset mid-clear: the sequence aborts to IDLE on that edge. Words already cleared stay cleared; the rest keep their old values. No clr_done is produced.
- clr_busy = (state == CLEAR). It is high for exactly byte_count cycles per clear.
- Clear latency: clr_req sampled at edge N; clr_done high in cycle N+byte_count. A new clr_req can be accepted at the edge that ends the clr_done cycle.
- Write-to-read latency: one edge. A read of waddr in the same cycle as the write returns the old value unless bypass is enabled.

## Configuration
- DAT_MEM_MP_BYPASS_EN defined: write-through forwarding. When write_en=1, state IDLE and raddr[i]==waddr, data_out[i] = data_in in the same cycle.
- DAT_MEM_MP_BYPASS_EN undefined: reads return stored contents only (old data on a same-address collision).
- The bypass never forwards dropped writes issued during CLEAR.

## Structure
- Package dat_mem_pkg holds:
  - typedef enum logic {IDLE, CLEAR} clr_state_t
  - a localparam function for address width
- Sub-module dat_mem_clr_seq holds the FSM, ptr counter, clr_busy, clr_done and wr_drop. It outputs a clear write enable and address to the array.
- Top level holds the array, the write mux (external vs. clear) and the read ports.

## Test plan
- Write 0xA5 to address 4, then read it on port 0 and 0x3C written to address 55 on port 1 in the same cycle → data_out = {0xA5, 0x3C}.
- Same-cycle write 0x77 and read of address 10, old value 0x11 → 0x11 without the macro, 0x77 with DAT_MEM_MP_BYPASS_EN; 0x77 on the next cycle in both builds.
- Fill memory with 0xFF, pulse clr_req → clr_busy high for exactly 256 cycles, clr_done pulses once, every address reads 0x00.
- Issue write_en to address 128 with 0x5A mid-clear → wr_drop=1, address 128 reads 0x00 after done, and wr_drop clears on the next clr_req.
- Deassert rst_n at ptr=100 during a clear → clr_busy=0 next cycle, no clr_done, addresses 0–99 read 0x00, address 100 and above keep 0xFF.
- With CLR_ON_RST=1, release reset → clr_busy rises on the first cycle and clr_done arrives byte_count cycles later.
